alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//   Shares the single 8-bit EX-stage ALU (mov/add) between two requesters:
//   pipeline EX (port 0) and the auxiliary/debug datapath (port 1).
//   - Round-robin arbitration; valid/ready handshake per requester.
//   - Drives the ALU operand/op inputs and captures its combinational result.
//   - One-entry registered response buffer with backpressure.
// PARAMETERS
//   DATA_W  8   operand/result width
//   CNT_W   16  width of per-requester grant counters (optional feature only)
// PORTS
//   Clk          in   1       single clock, rising edge
//   Reset_N      in   1       asynchronous, active-low reset
//   Req0_Valid   in   1       requester 0 has an operation
//   Req0_Data1   in   DATA_W  requester 0 operand 1
//   Req0_Data2   in   DATA_W  requester 0 operand 2
//   Req0_Op      in   1       0 = mov (result=Data1), 1 = add
//   Req0_Ready   out  1       requester 0 accepted this cycle
//   Req1_Valid/Req1_Data1/Req1_Data2/Req1_Op/Req1_Ready  same, requester 1
//   Alu_Data1    out  DATA_W  to ALU Data1_Final
//   Alu_Data2    out  DATA_W  to ALU Data2_Final
//   Alu_Op       out  1       to ALU ALU_Op
//   Alu_Result   in   DATA_W  from ALU ALU_Result (combinational)
//   Rsp_Valid    out  1       response buffer holds a result
//   Rsp_Data     out  DATA_W  result
//   Rsp_Id       out  1       requester that issued the result
//   Rsp_Ready    in   1       consumer takes result when Rsp_Valid=1
//   Grant_Cnt0   out  CNT_W   accepted ops, requester 0 (see CONFIGURATION)
//   Grant_Cnt1   out  CNT_W   accepted ops, requester 1
// BEHAVIOUR
//   - Reset (async, Reset_N=0): Rsp_Valid=0, Rsp_Data=0, Rsp_Id=0, Last_Grant=1
//     (requester 0 wins first tie), state EMPTY, Grant_Cnt0/1=0. Reset
//     mid-operation discards any held result; nothing is replayed.
//   - States: EMPTY (Rsp_Valid=0), FULL (Rsp_Valid=1).
//     Can_Accept = EMPTY | (FULL & Rsp_Ready).
//     EMPTY --accept--> FULL; FULL --Rsp_Ready & !accept--> EMPTY;
//     FULL --Rsp_Ready & accept--> FULL (new result, back-to-back).
//   - Grant (combinational): only one valid -> that one; both valid -> the one
//     != Last_Grant; none -> no grant. ReqN_Ready = Grant==N & Can_Accept.
//   - Accept = Valid & Ready; at most one port accepted per cycle. Last_Grant
//     updates only on accept; a grant blocked by !Can_Accept leaves it unchanged.
//   - Alu_Data1/Data2/Op mux the granted requester; with no grant they hold
//     requester 0 inputs (the ALU holds no state, so values are don't-care).
//   - On accept: Rsp_Data <= Alu_Result, Rsp_Id <= granted port, both at the
//     next rising edge. Latency: accept in cycle N -> Rsp_Valid=1 in N+1.
//   - Arithmetic: add wraps modulo 2^DATA_W, no carry out; mov passes Data1.
//   - Rsp_Data/Rsp_Id stable while Rsp_Valid=1 & Rsp_Ready=0.
//   - Requesters must hold Valid and operands stable until Ready; deasserting
//     Valid before Ready withdraws the request and is permitted.
//   - Throughput: 1 op/cycle when Rsp_Ready is held high; alternates ports
//     under continuous contention.
// CONFIGURATION
//   ALU_ARB_STATS_EN defined: Grant_Cnt0/1 increment on each accept of their
//     port, saturate at all-ones, clear only on reset.
//   ALU_ARB_STATS_EN undefined: Grant_Cnt0/1 tied to 0 and no counter
//     registers are built. Ports present in both builds.
// TESTING
//   1 Reset, only Req0 valid, D1=8'h05 D2=8'h03 Op=1, Rsp_Ready=1 ->
//     Req0_Ready=1 same cycle; next cycle Rsp_Valid=1 Rsp_Data=8'h08 Rsp_Id=0.
//   2 Both valid every cycle, Rsp_Ready=1 -> grants 0,1,0,1; Rsp_Id alternates
//     starting at 0; one result per cycle.
//   3 Req1 D1=8'hFF D2=8'h02 Op=1 -> Rsp_Data=8'h01; Op=0 D1=8'hA5 ->
//     Rsp_Data=8'hA5.
//   4 FULL with Rsp_Ready=0 for 3 cycles, Req0 valid -> Req0_Ready=0,
//     Rsp_Data stable; Rsp_Ready=1 -> Req0 accepted that cycle, new result
//     next cycle.
//   5 Reset_N pulsed low while FULL -> Rsp_Valid=0 immediately (async);
//     after release, tie goes to requester 0.
//   6 ALU_ARB_STATS_EN: 3 accepts Req0, 2 accepts Req1 -> Grant_Cnt0=3,
//     Grant_Cnt1=2. With CNT_W=2, 5 accepts saturate at 3. Undefined -> both 0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational mov/add ALU between two requesters,
// with a one-entry response buffer. Define ALU_ARB_STATS_EN to build grant counters.
module alu_share_arbiter #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset_N,
  input  logic              Req0_Valid,
  input  logic [DATA_W-1:0] Req0_Data1,
  input  logic [DATA_W-1:0] Req0_Data2,
  input  logic              Req0_Op,
  output logic              Req0_Ready,
  input  logic              Req1_Valid,
  input  logic [DATA_W-1:0] Req1_Data1,
  input  logic [DATA_W-1:0] Req1_Data2,
  input  logic              Req1_Op,
  output logic              Req1_Ready,
  output logic [DATA_W-1:0] Alu_Data1,
  output logic [DATA_W-1:0] Alu_Data2,
  output logic              Alu_Op,
  input  logic [DATA_W-1:0] Alu_Result,
  output logic              Rsp_Valid,
  output logic [DATA_W-1:0] Rsp_Data,
  output logic              Rsp_Id,
  input  logic              Rsp_Ready,
  output logic [CNT_W-1:0]  Grant_Cnt0,
  output logic [CNT_W-1:0]  Grant_Cnt1
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t state;
  logic   last_grant;
  logic   grant_valid;
  logic   grant_id;
  logic   can_accept;
  logic   accept;

  // With no grant, grant_id stays 0 so the ALU sees requester 0 inputs.
  always_comb begin
    grant_valid = Req0_Valid | Req1_Valid;
    grant_id    = 1'b0;
    if (Req0_Valid && Req1_Valid)
      grant_id = ~last_grant;
    else if (Req1_Valid)
      grant_id = 1'b1;
  end

  assign can_accept = (state == EMPTY) || Rsp_Ready;
  assign accept     = grant_valid && can_accept;
  assign Req0_Ready = accept && !grant_id;
  assign Req1_Ready = accept && grant_id;

  assign Alu_Data1 = grant_id ? Req1_Data1 : Req0_Data1;
  assign Alu_Data2 = grant_id ? Req1_Data2 : Req0_Data2;
  assign Alu_Op    = grant_id ? Req1_Op    : Req0_Op;

  assign Rsp_Valid = (state == FULL);

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state      <= EMPTY;
      Rsp_Data   <= '0;
      Rsp_Id     <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      state      <= FULL;
      Rsp_Data   <= Alu_Result;
      Rsp_Id     <= grant_id;
      last_grant <= grant_id;
    end else if (Rsp_Ready) begin
      state <= EMPTY;
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (Req0_Ready && (cnt0 != '1))
        cnt0 <= cnt0 + CNT_W'(1);
      if (Req1_Ready && (cnt1 != '1))
        cnt1 <= cnt1 + CNT_W'(1);
    end
  end

  assign Grant_Cnt0 = cnt0;
  assign Grant_Cnt1 = cnt1;
`else
  assign Grant_Cnt0 = '0;
  assign Grant_Cnt1 = '0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter; a second instance with
// CNT_W=2 shares the stimulus to exercise counter saturation.
module tb_alu_share_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req1_valid, req0_op, req1_op, rsp_ready;
  logic [7:0] req0_d1, req0_d2, req1_d1, req1_d2;

  logic       req0_ready, req1_ready, alu_op, rsp_valid, rsp_id;
  logic [7:0] alu_d1, alu_d2, alu_result, rsp_data;
  logic [15:0] cnt0, cnt1;

  logic       b_req0_ready, b_req1_ready, b_alu_op, b_rsp_valid, b_rsp_id;
  logic [7:0] b_alu_d1, b_alu_d2, b_alu_result, b_rsp_data;
  logic [1:0] b_cnt0, b_cnt1;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  // Reference ALU models sitting behind each instance.
  assign alu_result   = alu_op   ? alu_d1 + alu_d2     : alu_d1;
  assign b_alu_result = b_alu_op ? b_alu_d1 + b_alu_d2 : b_alu_d1;

  alu_share_arbiter #(.DATA_W(8), .CNT_W(16)) u_dut (
    .Clk(clk), .Reset_N(rst_n),
    .Req0_Valid(req0_valid), .Req0_Data1(req0_d1), .Req0_Data2(req0_d2),
    .Req0_Op(req0_op), .Req0_Ready(req0_ready),
    .Req1_Valid(req1_valid), .Req1_Data1(req1_d1), .Req1_Data2(req1_d2),
    .Req1_Op(req1_op), .Req1_Ready(req1_ready),
    .Alu_Data1(alu_d1), .Alu_Data2(alu_d2), .Alu_Op(alu_op),
    .Alu_Result(alu_result),
    .Rsp_Valid(rsp_valid), .Rsp_Data(rsp_data), .Rsp_Id(rsp_id),
    .Rsp_Ready(rsp_ready),
    .Grant_Cnt0(cnt0), .Grant_Cnt1(cnt1)
  );

  alu_share_arbiter #(.DATA_W(8), .CNT_W(2)) u_dut_sat (
    .Clk(clk), .Reset_N(rst_n),
    .Req0_Valid(req0_valid), .Req0_Data1(req0_d1), .Req0_Data2(req0_d2),
    .Req0_Op(req0_op), .Req0_Ready(b_req0_ready),
    .Req1_Valid(req1_valid), .Req1_Data1(req1_d1), .Req1_Data2(req1_d2),
    .Req1_Op(req1_op), .Req1_Ready(b_req1_ready),
    .Alu_Data1(b_alu_d1), .Alu_Data2(b_alu_d2), .Alu_Op(b_alu_op),
    .Alu_Result(b_alu_result),
    .Rsp_Valid(b_rsp_valid), .Rsp_Data(b_rsp_data), .Rsp_Id(b_rsp_id),
    .Rsp_Ready(rsp_ready),
    .Grant_Cnt0(b_cnt0), .Grant_Cnt1(b_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One isolated op on the given port; leaves time at posedge+1 after accept.
  task automatic single_op(input logic port, input logic [7:0] d1, input logic [7:0] d2,
                           input logic op);
    if (port) begin
      req1_valid = 1'b1; req1_d1 = d1; req1_d2 = d2; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_d1 = d1; req0_d2 = d2; req0_op = op;
    end
    @(posedge clk);
    #1 req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  initial begin
    req0_valid = 0; req1_valid = 0; req0_op = 0; req1_op = 0;
    req0_d1 = 0; req0_d2 = 0; req1_d1 = 0; req1_d2 = 0;
    rsp_ready = 1'b1;
    rst_n = 1'b0;
    #12;
    check_eq("reset_rsp_valid", rsp_valid, 0);
    check_eq("reset_rsp_data", rsp_data, 0);
    check_eq("reset_rsp_id", rsp_id, 0);
    check_eq("reset_cnt0", cnt0, 0);
    check_eq("reset_cnt1", cnt1, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Test 1: single add on port 0
    req0_valid = 1; req0_d1 = 8'h05; req0_d2 = 8'h03; req0_op = 1;
    #1;
    check_eq("t1_ready0", req0_ready, 1);
    check_eq("t1_ready1", req1_ready, 0);
    check_eq("t1_alu_d1", alu_d1, 8'h05);
    @(posedge clk);
    #1 req0_valid = 0;
    check_eq("t1_rsp_valid", rsp_valid, 1);
    check_eq("t1_rsp_data", rsp_data, 8'h08);
    check_eq("t1_rsp_id", rsp_id, 0);

    // Test 2: continuous contention from reset -> 0,1,0,1
    apply_reset();
    req0_valid = 1; req0_d1 = 8'h01; req0_d2 = 8'h01; req0_op = 1;
    req1_valid = 1; req1_d1 = 8'h0A; req1_d2 = 8'h14; req1_op = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq($sformatf("t2_ready0_%0d", i), req0_ready, (i % 2 == 0));
      check_eq($sformatf("t2_ready1_%0d", i), req1_ready, (i % 2 == 1));
      @(posedge clk);
      #1;
      check_eq($sformatf("t2_rsp_valid_%0d", i), rsp_valid, 1);
      check_eq($sformatf("t2_rsp_id_%0d", i), rsp_id, i % 2);
      check_eq($sformatf("t2_rsp_data_%0d", i), rsp_data, (i % 2 == 0) ? 8'h02 : 8'h1E);
    end
    req0_valid = 0; req1_valid = 0;
    @(posedge clk);
    #1 check_eq("t2_drain", rsp_valid, 0);

    // Test 3: wrap-around add then mov on port 1, back-to-back
    req1_valid = 1; req1_d1 = 8'hFF; req1_d2 = 8'h02; req1_op = 1;
    @(posedge clk);
    #1;
    check_eq("t3_add_wrap", rsp_data, 8'h01);
    check_eq("t3_add_id", rsp_id, 1);
    req1_d1 = 8'hA5; req1_d2 = 8'h3C; req1_op = 0;
    @(posedge clk);
    #1;
    check_eq("t3_mov", rsp_data, 8'hA5);
    check_eq("t3_mov_valid", rsp_valid, 1);

    // Test 4: backpressure while FULL
    req1_valid = 0; rsp_ready = 0;
    req0_valid = 1; req0_d1 = 8'h40; req0_d2 = 8'h02; req0_op = 1;
    for (int i = 0; i < 3; i++) begin
      #1 check_eq($sformatf("t4_blocked_%0d", i), req0_ready, 0);
      @(posedge clk);
      #1;
      check_eq($sformatf("t4_hold_data_%0d", i), rsp_data, 8'hA5);
      check_eq($sformatf("t4_hold_valid_%0d", i), rsp_valid, 1);
      check_eq($sformatf("t4_hold_id_%0d", i), rsp_id, 1);
    end
    rsp_ready = 1;
    #1 check_eq("t4_release_ready0", req0_ready, 1);
    @(posedge clk);
    #1;
    check_eq("t4_new_data", rsp_data, 8'h42);
    check_eq("t4_new_id", rsp_id, 0);
    req0_valid = 0;

    // Test 5: async reset while FULL, then tie goes to port 0
    #1 rst_n = 0;
    #1 check_eq("t5_async_clear", rsp_valid, 0);
    check_eq("t5_async_data", rsp_data, 0);
    #1 rst_n = 1;
    req0_valid = 1; req0_d1 = 8'h11; req0_d2 = 8'h00; req0_op = 0;
    req1_valid = 1; req1_d1 = 8'h22; req1_d2 = 8'h00; req1_op = 0;
    #1;
    check_eq("t5_tie_ready0", req0_ready, 1);
    check_eq("t5_tie_ready1", req1_ready, 0);
    @(posedge clk);
    #1 req0_valid = 0; req1_valid = 0;
    check_eq("t5_rsp_id", rsp_id, 0);
    check_eq("t5_rsp_data", rsp_data, 8'h11);

    // Test 6: grant counters
    apply_reset();
    for (int i = 0; i < 3; i++) single_op(1'b0, 8'(i), 8'h00, 1'b0);
    for (int i = 0; i < 2; i++) single_op(1'b1, 8'(i), 8'h00, 1'b0);
`ifdef ALU_ARB_STATS_EN
    check_eq("t6_cnt0", cnt0, 3);
    check_eq("t6_cnt1", cnt1, 2);
    check_eq("t6_sat_cnt0", b_cnt0, 3);
    check_eq("t6_sat_cnt1", b_cnt1, 2);
`else
    check_eq("t6_cnt0_off", cnt0, 0);
    check_eq("t6_cnt1_off", cnt1, 0);
    check_eq("t6_sat_cnt0_off", b_cnt0, 0);
    check_eq("t6_sat_cnt1_off", b_cnt1, 0);
`endif
    for (int i = 0; i < 2; i++) single_op(1'b0, 8'h01, 8'h01, 1'b1);
`ifdef ALU_ARB_STATS_EN
    check_eq("t6_cnt0_more", cnt0, 5);
    check_eq("t6_sat_cnt0_clamp", b_cnt0, 3);
`else
    check_eq("t6_cnt0_more_off", cnt0, 0);
    check_eq("t6_sat_cnt0_clamp_off", b_cnt0, 0);
`endif
    check_eq("t6_sat_rsp_data", b_rsp_data, 8'h02);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
